// File: rtl/vmp_engine.sv
// vmp_engine: sequential vector-matrix product engine.
//
// Multiplies an N_IN-element unsigned pixel vector by an N_IN x N_OUT signed
// fixed-point weight matrix (WGT_FRAC fraction bits). All N_OUT lanes
// accumulate in parallel, one input element per cycle. The results are
// saturated to ACC_W signed bits, keeping the weight fraction bits.
//
// Optional feature macro: VMP_RELU_EN. When defined, negative results are
// replaced by 0 after saturation, and overflow reports only positive clamping.
//
// Ports:
//   clk          in   rising-edge clock
//   GlobalReset  in   asynchronous active-high reset
//   in_valid     in   Pixels/Weights valid
//   in_ready     out  engine can accept a vector (IDLE and not in reset)
//   Pixels       in   element i at [i*PIX_W +: PIX_W], unsigned
//   Weights      in   weight i -> lane j at [(i*N_OUT+j)*WGT_W +: WGT_W], signed
//   out_valid    out  value/overflow valid (HOLD state)
//   out_ready    in   downstream accepts result
//   value        out  lane j at [j*ACC_W +: ACC_W], signed saturated
//   overflow     out  at least one lane clamped in this result
module vmp_engine #(
  parameter int unsigned N_IN     = 10,
  parameter int unsigned N_OUT    = 10,
  parameter int unsigned PIX_W    = 9,
  parameter int unsigned WGT_W    = 19,
  parameter int unsigned WGT_FRAC = 16,
  parameter int unsigned ACC_W    = 26
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*PIX_W-1:0]        Pixels,
  input  logic [N_IN*N_OUT*WGT_W-1:0]  Weights,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*ACC_W-1:0]       value,
  output logic                         overflow
);

  localparam int unsigned PROD_W    = PIX_W + WGT_W + 1;
  localparam int unsigned ACC_INT_W = PROD_W + $clog2(N_IN);
  localparam int unsigned IDX_W     = $clog2(N_IN + 1);

  // The fixed-point point position is only meaningful if it lies inside the weight.
  if (WGT_FRAC >= WGT_W) begin : g_bad_frac
    $error("vmp_engine: WGT_FRAC must be smaller than WGT_W");
  end

  typedef enum logic [1:0] {StIdle, StMac, StHold} state_e;

  state_e                      r_state, w_state_d;
  logic [IDX_W-1:0]            r_idx;
  logic [PIX_W-1:0]            r_pix [N_IN];
  logic [WGT_W-1:0]            r_wgt [N_IN][N_OUT];
  logic signed [ACC_INT_W-1:0] r_acc [N_OUT];
  logic signed [ACC_INT_W-1:0] w_acc_sum [N_OUT];
  logic signed [PROD_W-1:0]    w_prod [N_OUT];
  logic [N_OUT*ACC_W-1:0]      r_value, w_value_d;
  logic                        r_ovf, w_ovf_d;
  logic                        w_accept, w_mac_step, w_finish;

  assign w_accept   = (r_state == StIdle) && in_valid;
  // idx == N_IN marks the extra cycle that saturates and registers the result.
  assign w_mac_step = (r_state == StMac) && (r_idx != IDX_W'(N_IN));
  assign w_finish   = (r_state == StMac) && (r_idx == IDX_W'(N_IN));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StMac;
      StMac:   if (w_finish) w_state_d = StHold;
      StHold:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Latched operands are shifted down each MAC step, so element 0 is always current.
  always_comb begin : p_mac
    logic signed [PROD_W-1:0] pix_ext, wgt_ext;
    pix_ext = $signed({{WGT_W{1'b0}}, r_pix[0]});
    for (int j = 0; j < int'(N_OUT); j++) begin
      wgt_ext      = $signed({{(PIX_W + 1){r_wgt[0][j][WGT_W-1]}}, r_wgt[0][j]});
      w_prod[j]    = pix_ext * wgt_ext;
      w_acc_sum[j] = r_acc[j] + $signed({{(ACC_INT_W - PROD_W){w_prod[j][PROD_W-1]}},
                                         w_prod[j]});
    end
  end

  always_comb begin : p_sat
    logic [ACC_INT_W-ACC_W:0] upper;
    logic                     pos_clamp, neg_clamp;
    logic [ACC_W-1:0]         lane;
    w_value_d = '0;
    w_ovf_d   = 1'b0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      // The value fits when all bits from the result sign bit upward agree.
      upper     = r_acc[j][ACC_INT_W-1:ACC_W-1];
      pos_clamp = !r_acc[j][ACC_INT_W-1] && (|upper);
      neg_clamp = r_acc[j][ACC_INT_W-1] && !(&upper);
      if (pos_clamp) begin
        lane = {1'b0, {(ACC_W - 1){1'b1}}};
      end else if (neg_clamp) begin
        lane = {1'b1, {(ACC_W - 1){1'b0}}};
      end else begin
        lane = r_acc[j][ACC_W-1:0];
      end
`ifdef VMP_RELU_EN
      if (lane[ACC_W-1]) lane = '0;
      w_ovf_d = w_ovf_d | pos_clamp;
`else
      w_ovf_d = w_ovf_d | pos_clamp | neg_clamp;
`endif
      w_value_d[j*ACC_W +: ACC_W] = lane;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_value <= '0;
      r_ovf   <= 1'b0;
      for (int j = 0; j < int'(N_OUT); j++) r_acc[j] <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_idx <= '0;
        for (int j = 0; j < int'(N_OUT); j++) r_acc[j] <= '0;
      end else if (w_mac_step) begin
        r_idx <= r_idx + IDX_W'(1);
        for (int j = 0; j < int'(N_OUT); j++) r_acc[j] <= w_acc_sum[j];
      end
      if (w_finish) begin
        r_value <= w_value_d;
        r_ovf   <= w_ovf_d;
      end
    end
  end

  // Operand storage needs no reset: it is always loaded at the accept edge before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        r_pix[i] <= Pixels[i*PIX_W +: PIX_W];
        for (int j = 0; j < int'(N_OUT); j++) begin
          r_wgt[i][j] <= Weights[(i*N_OUT+j)*WGT_W +: WGT_W];
        end
      end
    end else if (w_mac_step) begin
      for (int i = 0; i < int'(N_IN) - 1; i++) begin
        r_pix[i] <= r_pix[i+1];
        for (int j = 0; j < int'(N_OUT); j++) r_wgt[i][j] <= r_wgt[i+1][j];
      end
    end
  end

  assign in_ready  = (r_state == StIdle) && !GlobalReset;
  assign out_valid = (r_state == StHold);
  assign value     = r_value;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_vmp_engine.sv
// Self-checking bench for vmp_engine: directed table vectors, backpressure,
// asynchronous reset mid-computation and randomized vectors against a
// plain-arithmetic reference model.
module tb_vmp_engine;

  localparam int unsigned N_IN  = 10;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned PIX_W = 9;
  localparam int unsigned WGT_W = 19;
  localparam int unsigned ACC_W = 26;
  localparam int unsigned PW    = N_IN * PIX_W;
  localparam int unsigned WW    = N_IN * N_OUT * WGT_W;
  localparam int unsigned VW    = N_OUT * ACC_W;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] Pixels;
  logic [WW-1:0] Weights;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] value;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  vmp_engine dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Pixels     (Pixels),
    .Weights    (Weights),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .value      (value),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [PW-1:0] pix;
    logic [WW-1:0] wgt;
    logic [VW-1:0] val;
    logic          ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] fill_pix(input int p);
    logic [PW-1:0] v;
    for (int i = 0; i < int'(N_IN); i++) v[i*PIX_W +: PIX_W] = PIX_W'(p);
    return v;
  endfunction

  function automatic logic [WW-1:0] fill_wgt(input logic [WGT_W-1:0] w);
    logic [WW-1:0] v;
    for (int k = 0; k < int'(N_IN * N_OUT); k++) v[k*WGT_W +: WGT_W] = w;
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_val(input logic [ACC_W-1:0] x);
    logic [VW-1:0] v;
    for (int j = 0; j < int'(N_OUT); j++) v[j*ACC_W +: ACC_W] = x;
    return v;
  endfunction

  // Reference: exact integer dot product per lane, then clamp (and ReLU if built).
  function automatic void model(input logic [PW-1:0] pix, input logic [WW-1:0] wgt,
                                output logic [VW-1:0] val, output logic ovf);
    longint mx, mn, s;
    logic signed [WGT_W-1:0] w;
    logic [PIX_W-1:0] p;
    mx  = (longint'(1) << (ACC_W - 1)) - 1;
    mn  = -(longint'(1) << (ACC_W - 1));
    ovf = 1'b0;
    val = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      s = 0;
      for (int i = 0; i < int'(N_IN); i++) begin
        p = pix[i*PIX_W +: PIX_W];
        w = wgt[(i*N_OUT+j)*WGT_W +: WGT_W];
        s += longint'(p) * longint'(w);
      end
      if (s > mx) begin
        s   = mx;
        ovf = 1'b1;
      end else if (s < mn) begin
        s = mn;
`ifndef VMP_RELU_EN
        ovf = 1'b1;
`endif
      end
`ifdef VMP_RELU_EN
      if (s < 0) s = 0;
`endif
      val[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
  endfunction

  // Offer one vector, scramble inputs after accept, check latency/result,
  // optionally stall out_ready for hold_cycles, then complete the handshake.
  task automatic run_vec(input string nm, input logic [PW-1:0] pix, input logic [WW-1:0] wgt,
                         input logic [VW-1:0] exp_val, input logic exp_ovf,
                         input int hold_cycles);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      step();
      cnt++;
    end
    chk({nm, " in_ready"}, VW'(in_ready), VW'(1));
    Pixels   = pix;
    Weights  = wgt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < int'(PW); k++) Pixels[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < int'(WW); k++) Weights[k] = 1'($urandom_range(0, 1));
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    chk({nm, " latency"}, VW'(cnt), VW'(N_IN + 1));
    chk({nm, " value"}, value, exp_val);
    chk({nm, " overflow"}, VW'(overflow), VW'(exp_ovf));
    for (int k = 0; k < hold_cycles; k++) begin
      step();
      chk({nm, " hold out_valid"}, VW'(out_valid), VW'(1));
      chk({nm, " hold in_ready"}, VW'(in_ready), VW'(0));
      chk({nm, " hold value"}, value, exp_val);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, VW'(out_valid), VW'(0));
    chk({nm, " in_ready back"}, VW'(in_ready), VW'(1));
  endtask

  vec_t tbl[4];

  initial begin
    logic [PW-1:0] pix;
    logic [WW-1:0] wgt;
    logic [VW-1:0] ev;
    logic          eo;
    logic [VW-1:0] v90;

    v90 = fill_val(26'h05A0000);

    // Pixels[i] = i with 2.0 weights: 2 * 45 = 90.0 on every lane.
    for (int i = 0; i < int'(N_IN); i++) pix[i*PIX_W +: PIX_W] = PIX_W'(i);
    tbl[0] = '{"ramp_x2", pix, fill_wgt(19'h20000), v90, 1'b0};
    tbl[1] = '{"sat_pos", fill_pix(511), fill_wgt(19'h3FFFF), fill_val(26'h1FFFFFF), 1'b1};
`ifdef VMP_RELU_EN
    tbl[2] = '{"neg_one", fill_pix(1), fill_wgt(19'h70000), '0, 1'b0};
`else
    tbl[2] = '{"neg_one", fill_pix(1), fill_wgt(19'h70000), fill_val(26'h3F60000), 1'b0};
`endif
    // Weight(i,j) = j*0.25 with pixels 4 gives lane j = 10*j.0 (lane 3 = 0x1E0000).
    for (int i = 0; i < int'(N_IN); i++)
      for (int j = 0; j < int'(N_OUT); j++)
        wgt[(i*N_OUT+j)*WGT_W +: WGT_W] = WGT_W'(j << 14);
    for (int j = 0; j < int'(N_OUT); j++) ev[j*ACC_W +: ACC_W] = ACC_W'((10 * j) << 16);
    tbl[3] = '{"per_lane", fill_pix(4), wgt, ev, 1'b0};

    in_valid    = 1'b0;
    out_ready   = 1'b0;
    Pixels      = '0;
    Weights     = '0;
    GlobalReset = 1'b1;
    #23;
    chk("reset in_ready", VW'(in_ready), VW'(0));
    chk("reset out_valid", VW'(out_valid), VW'(0));
    chk("reset value", value, '0);
    chk("reset overflow", VW'(overflow), VW'(0));
    GlobalReset = 1'b0;
    #1;
    chk("post-reset in_ready", VW'(in_ready), VW'(1));
    step();

    for (int t = 0; t < 4; t++) begin
      run_vec(tbl[t].nm, tbl[t].pix, tbl[t].wgt, tbl[t].val, tbl[t].ovf, 0);
    end
    chk("per_lane lane3", VW'(value[3*ACC_W +: ACC_W]), VW'(26'h01E0000));

    // Backpressure: five stalled cycles, then a vector whose inputs change after accept.
    run_vec("bp_stall", tbl[3].pix, tbl[3].wgt, tbl[3].val, 1'b0, 5);
    run_vec("bp_next", tbl[0].pix, tbl[0].wgt, v90, 1'b0, 0);

    // Asynchronous reset in the middle of MAC (idx = 4), then a fresh vector.
    run_vec("pre_rst", tbl[3].pix, tbl[3].wgt, tbl[3].val, 1'b0, 0);
    Pixels   = tbl[1].pix;
    Weights  = tbl[1].wgt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    GlobalReset = 1'b1;
    #1;
    chk("midrst out_valid", VW'(out_valid), VW'(0));
    chk("midrst value", value, '0);
    chk("midrst overflow", VW'(overflow), VW'(0));
    chk("midrst in_ready", VW'(in_ready), VW'(0));
    #2;
    GlobalReset = 1'b0;
    step();
    run_vec("post_rst", tbl[0].pix, tbl[0].wgt, v90, 1'b0, 0);

    // Randomized vectors: alternate small weights (no clamp) and full-range weights.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < int'(N_IN); i++) pix[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 511));
      for (int k = 0; k < int'(N_IN * N_OUT); k++) begin
        if (r % 2 == 0) wgt[k*WGT_W +: WGT_W] = WGT_W'(int'($urandom_range(0, 8192)) - 4096);
        else            wgt[k*WGT_W +: WGT_W] = WGT_W'($urandom);
      end
      model(pix, wgt, ev, eo);
      run_vec($sformatf("rand%0d", r), pix, wgt, ev, eo, r % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
